// File: rtl/wb_arbiter.sv
// Writeback arbiter: single-cycle ALU results win the register write port, long-latency results wait in a small FIFO.
// Optional macro WB_R0_DISCARD_EN suppresses register-file writes to r0 from either source.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int Q_DEPTH      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_wreg,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic              wb_stall,
  output logic              regwrite,
  output logic [ADDR_W-1:0] wreg,
  output logic [DATA_W-1:0] wdata,
  output logic              proto_err
);

  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(Q_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] q_wreg  [Q_DEPTH];
  logic [DATA_W-1:0] q_wdata [Q_DEPTH];
  logic [Q_DEPTH-1:0] q_kill;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_next;
  logic [ST_W-1:0]   starve, starve_next;
  logic              push, pop, alu_kills, alu_we, head_we;

  // An ALU write to r0 is dropped in discard mode, so it must not kill anything either.
  always_comb begin
    push = mem_valid && mem_ready;
    pop  = !alu_valid && (count != '0);
    count_next = count + CNT_W'(push) - CNT_W'(pop);
`ifdef WB_R0_DISCARD_EN
    alu_we  = (alu_wreg != '0);
    head_we = (q_wreg[head] != '0);
`else
    alu_we  = 1'b1;
    head_we = 1'b1;
`endif
    alu_kills = alu_valid && alu_we;
    if ((count == '0) || pop)
      starve_next = '0;
    else if (starve != ST_W'(STARVE_LIMIT))
      starve_next = starve + 1'b1;
    else
      starve_next = starve;
  end

  assign mem_ready = (count != CNT_W'(Q_DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      q_wreg[tail]  <= mem_wreg;
      q_wdata[tail] <= mem_wdata;
    end
  end

  // Killing a free slot is harmless: a push always rewrites its kill bit to 0, and
  // that later assignment makes the same-cycle push younger than the ALU write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_kill    <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      starve    <= '0;
      wb_stall  <= 1'b0;
      proto_err <= 1'b0;
      regwrite  <= 1'b0;
      wreg      <= '0;
      wdata     <= '0;
    end else begin
      for (int i = 0; i < Q_DEPTH; i++)
        if (alu_kills && (q_wreg[i] == alu_wreg))
          q_kill[i] <= 1'b1;
      if (push) begin
        q_kill[tail] <= 1'b0;
        tail         <= tail + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      count  <= count_next;
      starve <= starve_next;

      if (alu_valid) begin
        regwrite <= alu_we;
        wreg     <= alu_wreg;
        wdata    <= alu_wdata;
      end else if (pop && !q_kill[head]) begin
        regwrite <= head_we;
        wreg     <= q_wreg[head];
        wdata    <= q_wdata[head];
      end else begin
        regwrite <= 1'b0;
      end

      if (count_next == '0)
        wb_stall <= 1'b0;
      else if (starve_next == ST_W'(STARVE_LIMIT))
        wb_stall <= 1'b1;

      if (alu_valid && wb_stall)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based model of the writeback rules.
module tb_wb_arbiter;
  localparam int DW = 32, AW = 5, QD = 2, SL = 4;
`ifdef WB_R0_DISCARD_EN
  localparam bit R0D = 1'b1;
`else
  localparam bit R0D = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic alu_valid = 0, mem_valid = 0;
  logic [AW-1:0] alu_wreg = '0, mem_wreg = '0, wreg;
  logic [DW-1:0] alu_wdata = '0, mem_wdata = '0, wdata;
  logic mem_ready, wb_stall, regwrite, proto_err;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .Q_DEPTH(QD), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_wreg(alu_wreg), .alu_wdata(alu_wdata),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .wb_stall(wb_stall), .regwrite(regwrite),
    .wreg(wreg), .wdata(wdata), .proto_err(proto_err)
  );

  typedef struct {
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    bit            kill;
  } entry_t;

  entry_t        mq[$];
  int            m_starve;
  bit            m_stall, m_proto, m_rw;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  int vectors = 0, miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit wantsWrite(input logic [AW-1:0] idx);
    return !(R0D && idx == '0);
  endfunction

  task automatic modelReset();
    mq.delete();
    m_starve = 0; m_stall = 0; m_proto = 0; m_rw = 0; m_wreg = '0; m_wdata = '0;
  endtask

  // One clock edge of the writeback rules, applied to the queue model.
  task automatic modelEdge(input bit av, input logic [AW-1:0] aw, input logic [DW-1:0] ad,
                           input bit mv, input logic [AW-1:0] mw, input logic [DW-1:0] md);
    int old; bit push, pop; entry_t e;
    if (av && m_stall) m_proto = 1;
    old  = mq.size();
    push = mv && old < QD;
    pop  = !av && old > 0;
    if (av) begin
      if (wantsWrite(aw))
        foreach (mq[i]) if (mq[i].wreg == aw) mq[i].kill = 1;
      m_rw = wantsWrite(aw); m_wreg = aw; m_wdata = ad;
    end else if (pop) begin
      e = mq.pop_front();
      if (e.kill) m_rw = 0;
      else begin m_rw = wantsWrite(e.wreg); m_wreg = e.wreg; m_wdata = e.wdata; end
    end else m_rw = 0;
    if (old == 0 || pop) m_starve = 0;
    else if (m_starve < SL) m_starve++;
    if (push) begin e.wreg = mw; e.wdata = md; e.kill = 0; mq.push_back(e); end
    if (mq.size() == 0) m_stall = 0;
    else if (m_starve == SL) m_stall = 1;
  endtask

  task automatic applyStimulus(input bit av, input logic [AW-1:0] aw, input logic [DW-1:0] ad,
                               input bit mv, input logic [AW-1:0] mw, input logic [DW-1:0] md);
    alu_valid = av; alu_wreg = aw; alu_wdata = ad;
    mem_valid = mv; mem_wreg = mw; mem_wdata = md;
    #1;
    checkOutput("mem_ready", 64'(mem_ready), 64'(mq.size() != QD));
    @(posedge clk);
    modelEdge(av, aw, ad, mv, mw, md);
    #1;
    checkOutput("regwrite", 64'(regwrite), 64'(m_rw));
    checkOutput("wreg", 64'(wreg), 64'(m_wreg));
    checkOutput("wdata", 64'(wdata), 64'(m_wdata));
    checkOutput("wb_stall", 64'(wb_stall), 64'(m_stall));
    checkOutput("proto_err", 64'(proto_err), 64'(m_proto));
  endtask

  task automatic doReset();
    rst = 1'b1;
    alu_valid = 0; mem_valid = 0;
    #1;
    checkOutput("rst_regwrite", 64'(regwrite), 64'd0);
    checkOutput("rst_wreg", 64'(wreg), 64'd0);
    checkOutput("rst_wdata", 64'(wdata), 64'd0);
    checkOutput("rst_wb_stall", 64'(wb_stall), 64'd0);
    checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
    checkOutput("rst_mem_ready", 64'(mem_ready), 64'd1);
    modelReset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    doReset();

    $display("[TB] ALU only");
    applyStimulus(1, 5'd3, 32'h11, 0, 0, 0);
    checkOutput("alu_only_wreg", 64'(wreg), 64'd3);
    checkOutput("alu_only_wdata", 64'(wdata), 64'h11);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] memory only");
    applyStimulus(0, 0, 0, 1, 5'd7, 32'hAB);
    checkOutput("mem_no_bypass", 64'(regwrite), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mem_only_wdata", 64'(wdata), 64'hAB);

    $display("[TB] fill and back-pressure");
    applyStimulus(1, 5'd1, 32'h1, 1, 5'd10, 32'hA0);
    applyStimulus(1, 5'd2, 32'h2, 1, 5'd11, 32'hA1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 5'd4, 32'(i), 0, 0, 0);
    checkOutput("fill_stall_set", 64'(wb_stall), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drain_last_wreg", 64'(wreg), 64'd11);
    checkOutput("drain_stall_clr", 64'(wb_stall), 64'd0);

    $display("[TB] WAW kill");
    applyStimulus(1, 5'd9, 32'h9, 1, 5'd5, 32'h1);
    applyStimulus(1, 5'd5, 32'h2, 1, 5'd5, 32'h3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("waw_bubble", 64'(regwrite), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("waw_young_kept", 64'(wdata), 64'h3);

    $display("[TB] protocol error and mid-drain reset");
    applyStimulus(1, 5'd1, 32'h1, 1, 5'd12, 32'hC0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 5'd2, 32'(i), 0, 0, 0);
    applyStimulus(1, 5'd20, 32'hEE, 0, 0, 0);
    checkOutput("proto_set", 64'(proto_err), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);

    if (R0D) begin
      $display("[TB] r0 discard");
      applyStimulus(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      bit av;
      if ($urandom_range(0, 149) == 0) doReset();
      av = m_stall ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
      applyStimulus(av, 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
